register_file_mp: RTL and testbench
===================================

Name: register_file_mp

Overview:
Parametrised multi-port successor to register_array for the CPU datapath. Provides N combinational read ports and M synchronous write ports. Same-cycle write-to-read forwarding lets decode see a value in the cycle it is written back. Adds an optional hard-wired zero register and a per-register busy scoreboard that the hazard unit uses to stall issue.

Parameters:
register_num, 32, number of registers; power of two, >=2
register_width, 32, bits per register
read_ports, 2, number of read ports (>=1)
write_ports, 2, number of write ports (>=1)
zero_reg, 1, 1 = register 0 reads 0, ignores writes, never busy

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
read_address  input  read_ports*AW  packed read addresses; port k at [k*AW +: AW]; AW = $clog2(register_num)
read_data  output  read_ports*register_width  packed read data, combinational
read_busy  output  read_ports  busy bit of each addressed register, combinational
write_enable  input  write_ports  per-port write strobe
write_address  input  write_ports*AW  packed write addresses
write_data  input  write_ports*register_width  packed write data
mark_enable  input  1  set busy bit of mark_address (instruction issued, result pending)
mark_address  input  AW  destination register being marked
busy_vector  output  register_num  full scoreboard, bit i = register i busy

Behaviour:
- Reset: on a rising edge with rst=1, all registers are cleared to 0 and all busy bits to 0. Write and mark inputs are ignored in that cycle. read_data therefore reads 0 and busy_vector reads 0 from the following cycle on. Reset mid-operation discards in-flight marks.
- Write: on a rising edge with write_enable[j]=1, register at write_address[j] takes write_data[j].
- Multi-port write to the same address in one cycle: the highest-index enabled port wins.
- Read: read_data[k] = storage[read_address[k]], combinational, zero-cycle latency.
- Bypass: if any write port is enabled to read_address[k] in the current cycle, read_data[k] returns that port's write_data. The same highest-index priority applies. Bypass is suppressed while rst=1 (output is storage).
- zero_reg=1:
  - writes and marks to address 0 are dropped;
  - read_data for address 0 = 0, including under bypass;
  - read_busy and busy_vector[0] = 0.
- Scoreboard:
  - A busy bit is set on a rising edge with mark_enable=1 at mark_address.
  - A busy bit is cleared on a rising edge when any enabled write port targets that address.
  - If a mark and a write hit the same address in the same cycle, the mark wins (bit stays 1; new producer).
- read_busy[k] = busy_vector[read_address[k]] as registered, not bypassed. A write in the current cycle does not clear the reported busy until the next cycle; the hazard unit instead uses the bypassed data.
- Out-of-range addresses cannot occur (register_num is a power of two).
- Registers hold their value indefinitely with no enables asserted.

Decomposition:
- Shared package rf_pkg holds:
  - AW derivation (clog2 function);
  - the ZERO_ADDR constant;
  - port slice helper macros for packed read/write buses.
- One sub-module, rf_scoreboard, is natural: busy_vector register, mark/clear logic with the mark-wins rule, and zero_reg masking.
- Storage, write-priority mux and bypass stay in the top module.

Test Plan:
- Reset then write: rst 1 cycle; then write port0 r1=20 and port1 r2=30 in the same cycle. Next cycle read r1, r2 -> 20, 30. Before any write, all reads -> 0.
- Write-port conflict: port0 and port1 both write r5 (0x11, 0x22) in the same cycle. Read r5 -> 0x22. Bypass in the write cycle also shows 0x22.
- Bypass: write r9=-10 (0xFFFFFFF6) while read_address0=9 in the same cycle. read_data0 = 0xFFFFFFF6 before the edge, and storage holds it after.
- Zero register: write r0=10 with zero_reg=1 -> read r0 = 0, bypass r0 = 0. mark r0 -> busy_vector[0] = 0. With zero_reg=0, the same write reads back 10.
- Scoreboard:
  - mark r7 -> next cycle read_busy for r7 = 1;
  - write r7=44 -> read_busy drops to 0 the cycle after;
  - mark r7 and write r7 in the same cycle -> stays 1.
- Reset mid-operation: registers r1, r2, r5, r9 loaded and r3 marked busy. Assert rst for 1 cycle concurrently with a write to r4. All reads -> 0, busy_vector = 0, and r4 not written.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: address-width helper,
// the hard-wired zero register address and packed-bus slice helper.
`ifndef RF_PKG_MACROS
`define RF_PKG_MACROS
`define RF_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]
`endif

package rf_pkg;

  localparam int ZERO_ADDR = 0;

  // Address width for a register count; never below 1 so a 2-entry file still has an address bit.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Bus bundle between the datapath (master) and the register file (slave).
interface register_file_mp_if
  import rf_pkg::*;
#(
  parameter int register_num   = 32,
  parameter int register_width = 32,
  parameter int read_ports     = 2,
  parameter int write_ports    = 2
);
  localparam int AW = clog2(register_num);

  logic [read_ports*AW-1:0]              read_address;
  logic [read_ports*register_width-1:0]  read_data;
  logic [read_ports-1:0]                 read_busy;
  logic [write_ports-1:0]                write_enable;
  logic [write_ports*AW-1:0]             write_address;
  logic [write_ports*register_width-1:0] write_data;
  logic                                  mark_enable;
  logic [AW-1:0]                         mark_address;
  logic [register_num-1:0]               busy_vector;

  modport master (
    output read_address, write_enable, write_address, write_data, mark_enable, mark_address,
    input  read_data, read_busy, busy_vector
  );

  modport slave (
    input  read_address, write_enable, write_address, write_data, mark_enable, mark_address,
    output read_data, read_busy, busy_vector
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: marks set a bit, writes clear it, and a mark
// landing with a write in the same cycle keeps the bit set (new producer).
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int register_num = 32,
  parameter int write_ports  = 2,
  parameter int zero_reg     = 1,
  parameter int AW           = clog2(register_num)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [write_ports-1:0]      i_write_enable,
  input  logic [write_ports*AW-1:0]   i_write_address,
  input  logic                        i_mark_enable,
  input  logic [AW-1:0]               i_mark_address,
  output logic [register_num-1:0]     o_busy_vector
);

  logic [register_num-1:0] r_busy;
  logic [register_num-1:0] w_clear;
  logic [register_num-1:0] w_set;

  always_comb begin
    w_clear = '0;
    for (int j = 0; j < write_ports; j++) begin
      if (i_write_enable[j]) w_clear[`RF_SLICE(i_write_address, j, AW)] = 1'b1;
    end
    w_set = '0;
    if (i_mark_enable) w_set[i_mark_address] = 1'b1;
    if (zero_reg != 0) w_set[ZERO_ADDR] = 1'b0;
  end

  // Set term is OR-ed after the clear so a same-cycle mark overrides the write.
  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_set | (r_busy & ~w_clear);
  end

  assign o_busy_vector = (zero_reg != 0) ? (r_busy & ~register_num'(1)) : r_busy;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: N combinational read ports with same-cycle write
// bypass, M write ports (highest index wins), optional zero register, busy scoreboard.
module register_file_mp
  import rf_pkg::*;
#(
  parameter int register_num   = 32,
  parameter int register_width = 32,
  parameter int read_ports     = 2,
  parameter int write_ports    = 2,
  parameter int zero_reg       = 1
) (
  input logic               clk,
  input logic               rst,
  register_file_mp_if.slave bus
);

  localparam int AW = clog2(register_num);

  logic [register_width-1:0] r_mem [register_num];
  logic [register_num-1:0]   w_busy;

  // Later ports are visited last, so their non-blocking write is the one that sticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < register_num; i++) r_mem[i] <= '0;
    end else begin
      for (int j = 0; j < write_ports; j++) begin
        if (bus.write_enable[j] &&
            !(zero_reg != 0 && `RF_SLICE(bus.write_address, j, AW) == AW'(ZERO_ADDR)))
          r_mem[`RF_SLICE(bus.write_address, j, AW)] <= `RF_SLICE(bus.write_data, j, register_width);
      end
    end
  end

  for (genvar k = 0; k < read_ports; k++) begin : g_read
    logic [AW-1:0]             w_raddr;
    logic [register_width-1:0] w_rdata;

    assign w_raddr = `RF_SLICE(bus.read_address, k, AW);

    // Bypass scans ports in ascending order so the highest enabled port wins, like storage.
    always_comb begin
      w_rdata = r_mem[w_raddr];
      if (!rst) begin
        for (int j = 0; j < write_ports; j++) begin
          if (bus.write_enable[j] && `RF_SLICE(bus.write_address, j, AW) == w_raddr)
            w_rdata = `RF_SLICE(bus.write_data, j, register_width);
        end
      end
      if (zero_reg != 0 && w_raddr == AW'(ZERO_ADDR)) w_rdata = '0;
    end

    assign `RF_SLICE(bus.read_data, k, register_width) = w_rdata;
    assign bus.read_busy[k] = w_busy[w_raddr];
  end

  rf_scoreboard #(
    .register_num (register_num),
    .write_ports  (write_ports),
    .zero_reg     (zero_reg),
    .AW           (AW)
  ) u_scoreboard (
    .clk             (clk),
    .rst             (rst),
    .i_write_enable  (bus.write_enable),
    .i_write_address (bus.write_address),
    .i_mark_enable   (bus.mark_enable),
    .i_mark_address  (bus.mark_address),
    .o_busy_vector   (w_busy)
  );

  assign bus.busy_vector = w_busy;

endmodule

// File: tb/tb_register_file_mp.sv
// Directed table-driven bench for register_file_mp; a second instance with the
// zero register disabled shares the same stimulus.
module tb_register_file_mp;

  typedef struct {
    logic        rst;
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        me;
    logic [4:0]  ma;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        chk;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
    logic [31:0] ebv;
    logic        zc;
    logic [31:0] ez0;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   compared = 0;
  int   mismatched = 0;
  vec_t vecs [19];

  always #5 clk = ~clk;

  register_file_mp_if #(.register_num(32), .register_width(32), .read_ports(2), .write_ports(2)) busIf ();
  register_file_mp_if #(.register_num(32), .register_width(32), .read_ports(2), .write_ports(2)) busZ ();

  assign busZ.read_address  = busIf.read_address;
  assign busZ.write_enable  = busIf.write_enable;
  assign busZ.write_address = busIf.write_address;
  assign busZ.write_data    = busIf.write_data;
  assign busZ.mark_enable   = busIf.mark_enable;
  assign busZ.mark_address  = busIf.mark_address;

  register_file_mp #(.register_num(32), .register_width(32), .read_ports(2), .write_ports(2), .zero_reg(1))
    dut (.clk(clk), .rst(rst), .bus(busIf));

  register_file_mp #(.register_num(32), .register_width(32), .read_ports(2), .write_ports(2), .zero_reg(0))
    dutZ (.clk(clk), .rst(rst), .bus(busZ));

  function automatic vec_t mkVec(
      logic r, logic [1:0] we, logic [4:0] wa0, logic [31:0] wd0, logic [4:0] wa1, logic [31:0] wd1,
      logic me, logic [4:0] ma, logic [4:0] ra0, logic [4:0] ra1, logic chk,
      logic [31:0] e0, logic [31:0] e1, logic [1:0] eb, logic [31:0] ebv, logic zc, logic [31:0] ez0);
    vec_t v;
    v.rst = r;   v.we = we;   v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.me = me;   v.ma = ma;   v.ra0 = ra0; v.ra1 = ra1; v.chk = chk;
    v.e0 = e0;   v.e1 = e1;   v.eb = eb;   v.ebv = ebv; v.zc = zc;   v.ez0 = ez0;
    return v;
  endfunction

  // Drive every bus input from one record; called just after a falling edge.
  task automatic applyStimulus(input vec_t v);
    rst                 = v.rst;
    busIf.write_enable  = v.we;
    busIf.write_address = {v.wa1, v.wa0};
    busIf.write_data    = {v.wd1, v.wd0};
    busIf.mark_enable   = v.me;
    busIf.mark_address  = v.ma;
    busIf.read_address  = {v.ra1, v.ra0};
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idleVec(input logic [4:0] ra0, input logic [4:0] ra1);
    applyStimulus(mkVec(0, 2'b00, 0, 0, 0, 0, 0, 0, ra0, ra1, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    //                 rst we     wa0 wd0           wa1 wd1    me ma ra0 ra1 chk e0            e1     eb     ebv    zc ez0
    vecs[0]  = mkVec(1, 2'b00, 0,  0,            0,  0,     0, 0, 1,  2,  0,  0,            0,     2'b00, 0,     0, 0);
    vecs[1]  = mkVec(0, 2'b00, 0,  0,            0,  0,     0, 0, 1,  2,  1,  0,            0,     2'b00, 0,     0, 0);
    vecs[2]  = mkVec(0, 2'b11, 1,  20,           2,  30,    0, 0, 1,  2,  1,  20,           30,    2'b00, 0,     0, 0);
    vecs[3]  = mkVec(0, 2'b00, 0,  0,            0,  0,     0, 0, 1,  2,  1,  20,           30,    2'b00, 0,     0, 0);
    vecs[4]  = mkVec(0, 2'b11, 5,  32'h11,       5,  32'h22, 0, 0, 5, 5,  1,  32'h22,       32'h22, 2'b00, 0,    0, 0);
    vecs[5]  = mkVec(0, 2'b00, 0,  0,            0,  0,     0, 0, 5,  1,  1,  32'h22,       20,    2'b00, 0,     0, 0);
    vecs[6]  = mkVec(0, 2'b01, 9,  32'hFFFFFFF6, 0,  0,     0, 0, 9,  5,  1,  32'hFFFFFFF6, 32'h22, 2'b00, 0,    0, 0);
    vecs[7]  = mkVec(0, 2'b00, 0,  0,            0,  0,     0, 0, 9,  2,  1,  32'hFFFFFFF6, 30,    2'b00, 0,     0, 0);
    vecs[8]  = mkVec(0, 2'b10, 0,  0,            0,  10,    1, 0, 0,  0,  1,  0,            0,     2'b00, 0,     1, 10);
    vecs[9]  = mkVec(0, 2'b00, 0,  0,            0,  0,     0, 0, 0,  0,  1,  0,            0,     2'b00, 0,     1, 10);
    vecs[10] = mkVec(0, 2'b00, 0,  0,            0,  0,     1, 7, 7,  0,  1,  0,            0,     2'b00, 0,     0, 0);
    vecs[11] = mkVec(0, 2'b01, 7,  44,           0,  0,     0, 0, 7,  0,  1,  44,           0,     2'b01, 32'h80, 0, 0);
    vecs[12] = mkVec(0, 2'b00, 0,  0,            0,  0,     0, 0, 7,  0,  1,  44,           0,     2'b00, 0,     0, 0);
    vecs[13] = mkVec(0, 2'b10, 0,  0,            7,  32'h55, 1, 7, 7, 0,  1,  32'h55,       0,     2'b00, 0,     0, 0);
    vecs[14] = mkVec(0, 2'b00, 0,  0,            0,  0,     1, 3, 7,  3,  1,  32'h55,       0,     2'b01, 32'h80, 0, 0);
    vecs[15] = mkVec(1, 2'b01, 4,  32'h44,       0,  0,     1, 6, 4,  7,  1,  0,            32'h55, 2'b10, 32'h88, 0, 0);
    vecs[16] = mkVec(0, 2'b00, 0,  0,            0,  0,     0, 0, 4,  7,  1,  0,            0,     2'b00, 0,     0, 0);
    vecs[17] = mkVec(0, 2'b00, 0,  0,            0,  0,     0, 0, 1,  9,  1,  0,            0,     2'b00, 0,     0, 0);
    vecs[18] = mkVec(0, 2'b00, 0,  0,            0,  0,     0, 0, 5,  3,  1,  0,            0,     2'b00, 0,     0, 0);

    // Each row: drive after the falling edge, sample 1 ns later, then let the rising edge commit.
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i]);
      #1;
      if (vecs[i].chk) begin
        checkOutput($sformatf("v%0d read_data0", i), busIf.read_data[31:0], vecs[i].e0);
        checkOutput($sformatf("v%0d read_data1", i), busIf.read_data[63:32], vecs[i].e1);
        checkOutput($sformatf("v%0d read_busy", i), {30'd0, busIf.read_busy}, {30'd0, vecs[i].eb});
        checkOutput($sformatf("v%0d busy_vector", i), busIf.busy_vector, vecs[i].ebv);
        if (vecs[i].zc)
          checkOutput($sformatf("v%0d nozero read_data0", i), busZ.read_data[31:0], vecs[i].ez0);
      end
      @(negedge clk);
    end

    // Disabled port 1 aimed at the same address must not bypass or write.
    applyStimulus(mkVec(0, 2'b01, 10, 32'h0A, 10, 32'h0B, 0, 0, 10, 10, 0, 0, 0, 0, 0, 0, 0));
    #1;
    checkOutput("disabled port bypass", busIf.read_data[31:0], 32'h0A);
    @(negedge clk);
    idleVec(10, 0);
    #1;
    checkOutput("disabled port storage", busIf.read_data[31:0], 32'h0A);
    @(negedge clk);

    // Storage and a busy mark both persist across a long idle stretch.
    applyStimulus(mkVec(0, 2'b10, 0, 0, 12, 32'hDEADBEEF, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    for (int c = 0; c < 25; c++) begin
      idleVec(12, 10);
      @(negedge clk);
    end
    #1;
    checkOutput("hold r12", busIf.read_data[31:0], 32'hDEADBEEF);
    checkOutput("hold r10", busIf.read_data[63:32], 32'h0A);
    checkOutput("hold busy r12", {30'd0, busIf.read_busy}, 32'd1);
    checkOutput("hold busy_vector", busIf.busy_vector, 32'h0000_1000);

    // A write from port 0 alone clears the mark on the following cycle.
    @(negedge clk);
    applyStimulus(mkVec(0, 2'b01, 12, 32'h1234, 0, 0, 0, 0, 12, 12, 0, 0, 0, 0, 0, 0, 0));
    #1;
    checkOutput("clear pending busy", {30'd0, busIf.read_busy}, 32'd3);
    @(negedge clk);
    idleVec(12, 0);
    #1;
    checkOutput("clear done busy_vector", busIf.busy_vector, 32'd0);
    checkOutput("clear done data", busIf.read_data[31:0], 32'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
